// File: rtl/seq_alu.sv
// seq_alu: handshaked MIPS-style ALU with registered results and iterative shift/multiply.
// Define SEQ_ALU_MUL_EN to build the shift-add multiplier for op 10.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             bne,
  output logic             ov,
  output logic             err
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_NOR = 4'd12;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SHW:0]       r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_rd;
  logic               r_bne;
  logic               r_ov;
  logic               r_err;
`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
`endif

  logic               w_sub;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_sx;
  logic [SHW-1:0]     w_shamt;
  logic               w_is_mul;
  logic [WIDTH-1:0]   w_res;
  logic               w_ov;
  logic               w_err;
  logic               w_multi;

  assign w_shamt = rt[SHW-1:0];
`ifdef SEQ_ALU_MUL_EN
  assign w_is_mul = (op == OP_MUL);
`else
  assign w_is_mul = 1'b0;
`endif

  // Sign-extended adder: top two bits disagree exactly on signed overflow
  assign w_sub = (op == OP_SUB) || (op == OP_SLT);
  assign w_b   = w_sub ? ~rt : rt;
  assign w_sx  = {rs[WIDTH-1], rs} + {w_b[WIDTH-1], w_b}
               + (WIDTH+1)'(w_sub);

  always_comb begin
    w_res   = '0;
    w_ov    = 1'b0;
    w_err   = 1'b0;
    w_multi = 1'b0;
    unique case (1'b1)
      op == OP_AND: w_res = rs & rt;
      op == OP_OR:  w_res = rs | rt;
      op == OP_NOR: w_res = ~(rs | rt);
      op == OP_ADD,
      op == OP_SUB: begin
        w_res = w_sx[WIDTH-1:0];
        w_ov  = w_sx[WIDTH] ^ w_sx[WIDTH-1];
      end
      op == OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_sx[WIDTH]};
      op == OP_SLL,
      op == OP_SRL: begin
        w_res   = rs;
        w_multi = (w_shamt != '0);
      end
      w_is_mul:     w_multi = 1'b1;
      default:      w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_multi ? S_EXEC : S_DONE;
      end
      S_EXEC: if (r_cnt == (SHW+1)'(1)) w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_rd  <= '0;
      r_bne <= 1'b0;
      r_ov  <= 1'b0;
      r_err <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      r_a   <= '0;
      r_b   <= '0;
`endif
    end else if (r_state == S_IDLE && in_valid) begin
      r_op  <= op;
      r_rd  <= w_res;
      r_bne <= (rs != rt);
      r_ov  <= w_ov;
      r_err <= w_err;
      r_cnt <= w_is_mul ? (SHW+1)'(WIDTH) : {1'b0, w_shamt};
`ifdef SEQ_ALU_MUL_EN
      r_a   <= rs;
      r_b   <= rt;
`endif
    end else if (r_state == S_EXEC) begin
      r_cnt <= r_cnt - (SHW+1)'(1);
      if (r_op == OP_SRL) begin
        r_rd <= r_rd >> 1;
`ifdef SEQ_ALU_MUL_EN
      end else if (r_op == OP_MUL) begin
        if (r_b[0]) r_rd <= r_rd + r_a;
        r_a <= r_a << 1;
        r_b <= r_b >> 1;
`endif
      end else begin
        r_rd <= r_rd << 1;
      end
    end
  end

  assign rd  = r_rd;
  assign bne = r_bne;
  assign ov  = r_ov;
  assign err = r_err;

endmodule
